d_sram2axi: RTL and testbench



---
 rtl/axi_pkg.sv | 24 ++
 rtl/sram_wstrb_gen.sv | 19 +
 rtl/d_sram2axi.sv | 186 ++++++++++++++++++
 tb/tb_d_sram2axi.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI3 constants, bridge state encoding and SRAM-like size codes
// for the single-beat cache-to-AXI bridges.
package axi_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [3:0] AXI_LEN_SINGLE = 4'd0;
    localparam logic [1:0] AXI_LOCK_NONE  = 2'd0;
    localparam logic [3:0] AXI_CACHE_NONE = 4'd0;
    localparam logic [2:0] AXI_PROT_NONE  = 3'd0;
    localparam logic [3:0] AXI_ID_DEFAULT = 4'd1;

    localparam logic [1:0] SRAM_SIZE_BYTE = 2'd0;
    localparam logic [1:0] SRAM_SIZE_HALF = 2'd1;
    localparam logic [1:0] SRAM_SIZE_WORD = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        RADDR,
        RDATA,
        WADDR,
        WRESP
    } state_e;

endpackage

// File: rtl/sram_wstrb_gen.sv
// Byte-lane strobe generator for SRAM-like size/address pairs; size 3
// falls through to the full-word strobe.
module sram_wstrb_gen
    import axi_pkg::*;
(
    input  logic [1:0] size,
    input  logic [1:0] addr_lo,
    output logic [3:0] wstrb
);

    always_comb begin
        unique case (size)
            SRAM_SIZE_BYTE: wstrb = 4'b0001 << addr_lo;
            SRAM_SIZE_HALF: wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
            default:        wstrb = 4'b1111;
        endcase
    end

endmodule

// File: rtl/d_sram2axi.sv
// Data-side SRAM-like to AXI3 bridge: one outstanding single-beat read or
// write, all AXI request fields driven from the latched request.
module d_sram2axi
    import axi_pkg::*;
#(
    parameter logic [3:0] AXI_ID = AXI_ID_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [3:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [3:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    state_e      state_q, state_d;
    logic        wr_q, wr_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic        aw_hs, w_hs;

    // Response ids/status are deliberately ignored: any response completes.
    logic unused_axi_inputs;
    assign unused_axi_inputs = ^{rid, rresp, rlast, bid, bresp, wr_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            wr_q      <= 1'b0;
            size_q    <= 2'd0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_q      <= wr_d;
            size_q    <= size_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        wr_d         = wr_q;
        size_d       = size_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        arvalid      = 1'b0;
        rready       = 1'b0;
        awvalid      = 1'b0;
        wvalid       = 1'b0;
        bready       = 1'b0;
        aw_hs        = 1'b0;
        w_hs         = 1'b0;

        unique case (state_q)
            IDLE: begin
                data_addr_ok = data_req;
                if (data_req) begin
                    wr_d    = data_wr;
                    size_d  = data_size;
                    addr_d  = data_addr;
                    wdata_d = data_wdata;
                    state_d = data_wr ? WADDR : RADDR;
                end
            end
            RADDR: begin
                arvalid = 1'b1;
                if (arready) state_d = RDATA;
            end
            RDATA: begin
                rready = 1'b1;
                if (rvalid) begin
                    data_data_ok = 1'b1;
                    state_d      = IDLE;
                end
            end
            WADDR: begin
                awvalid = ~aw_done_q;
                wvalid  = ~w_done_q;
                aw_hs   = ~aw_done_q & awready;
                w_hs    = ~w_done_q & wready;
                // Leave as soon as both channels are done, even if the
                // second handshake is happening right now.
                if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
                    state_d   = WRESP;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end else begin
                    aw_done_d = aw_done_q | aw_hs;
                    w_done_d  = w_done_q | w_hs;
                end
            end
            WRESP: begin
                bready = 1'b1;
                if (bvalid) begin
                    data_data_ok = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign data_rdata = rdata;

    assign arid    = AXI_ID;
    assign araddr  = addr_q;
    assign arlen   = AXI_LEN_SINGLE;
    assign arsize  = {1'b0, size_q};
    assign arburst = AXI_BURST_INCR;
    assign arlock  = AXI_LOCK_NONE;
    assign arcache = AXI_CACHE_NONE;
    assign arprot  = AXI_PROT_NONE;

    assign awid    = AXI_ID;
    assign awaddr  = addr_q;
    assign awlen   = AXI_LEN_SINGLE;
    assign awsize  = {1'b0, size_q};
    assign awburst = AXI_BURST_INCR;
    assign awlock  = AXI_LOCK_NONE;
    assign awcache = AXI_CACHE_NONE;
    assign awprot  = AXI_PROT_NONE;

    assign wid   = AXI_ID;
    assign wdata = wdata_q;
    assign wlast = 1'b1;

    sram_wstrb_gen u_wstrb_gen (
        .size    (size_q),
        .addr_lo (addr_q[1:0]),
        .wstrb   (wstrb)
    );

endmodule

// File: tb/tb_d_sram2axi.sv
// Directed bench for d_sram2axi: table of zero-wait transactions plus
// hand-written stall, reset and error-response sequences.
module tb_d_sram2axi;

    logic        clk;
    logic        rst;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    int checks = 0;
    int errors = 0;

    d_sram2axi #(.AXI_ID(4'd1)) dut (
        .clk(clk), .rst(rst),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        string       name;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdat;
        logic [31:0] rdat;
        logic [2:0]  exp_size;
        logic [3:0]  exp_wstrb;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic drive_req(input logic wr, input logic [1:0] size,
                             input logic [31:0] addr, input logic [31:0] wd);
        data_req   = 1'b1;
        data_wr    = wr;
        data_size  = size;
        data_addr  = addr;
        data_wdata = wd;
    endtask

    // Zero-wait slave: request at cycle 0, address/data handshake at cycle 1,
    // response at cycle 2.
    task automatic run_vec(input vec_t v);
        step();
        drive_req(v.wr, v.size, v.addr, v.wdat);
        settle();
        chk({v.name, " addr_ok c0"}, 32'(data_addr_ok), 32'd1);
        chk({v.name, " data_ok c0"}, 32'(data_data_ok), 32'd0);
        step();
        data_req = 1'b0;
        data_addr = 32'hFFFF_FFFF;
        data_wdata = 32'h5555_5555;
        if (v.wr) begin
            awready = 1'b1;
            wready  = 1'b1;
        end else begin
            arready = 1'b1;
        end
        settle();
        if (v.wr) begin
            chk({v.name, " awvalid"}, 32'(awvalid), 32'd1);
            chk({v.name, " wvalid"},  32'(wvalid),  32'd1);
            chk({v.name, " arvalid"}, 32'(arvalid), 32'd0);
            chk({v.name, " awaddr"},  awaddr, v.addr);
            chk({v.name, " awsize"},  32'(awsize), 32'(v.exp_size));
            chk({v.name, " wstrb"},   32'(wstrb), 32'(v.exp_wstrb));
            chk({v.name, " wdata"},   wdata, v.wdat);
            chk({v.name, " aw const"}, {awid, awlen, 6'd0, awburst, wid, 3'd0, wlast, 8'd0},
                {4'd1, 4'd0, 6'd0, 2'b01, 4'd1, 3'd0, 1'b1, 8'd0});
        end else begin
            chk({v.name, " arvalid"}, 32'(arvalid), 32'd1);
            chk({v.name, " awvalid"}, 32'(awvalid), 32'd0);
            chk({v.name, " araddr"},  araddr, v.addr);
            chk({v.name, " arsize"},  32'(arsize), 32'(v.exp_size));
            chk({v.name, " ar const"}, {arid, arlen, 6'd0, arburst, arlock, arcache, arprot, 7'd0},
                {4'd1, 4'd0, 6'd0, 2'b01, 2'd0, 4'd0, 3'd0, 7'd0});
        end
        chk({v.name, " addr_ok c1"}, 32'(data_addr_ok), 32'd0);
        step();
        arready = 1'b0;
        awready = 1'b0;
        wready  = 1'b0;
        if (v.wr) bvalid = 1'b1;
        else begin
            rvalid = 1'b1;
            rdata  = v.rdat;
        end
        settle();
        chk({v.name, " data_ok c2"}, 32'(data_data_ok), 32'd1);
        if (v.wr) chk({v.name, " bready"}, 32'(bready), 32'd1);
        else begin
            chk({v.name, " rready"}, 32'(rready), 32'd1);
            chk({v.name, " rdata"},  data_rdata, v.rdat);
        end
        step();
        rvalid = 1'b0;
        bvalid = 1'b0;
        settle();
        chk({v.name, " data_ok c3"}, 32'(data_data_ok), 32'd0);
    endtask

    initial begin
        int pulses;

        vecs[0] = '{"rd_word",    1'b0, 2'd0, 32'h0000_0000, 32'h0, 32'h0, 3'd0, 4'h0};
        vecs[0] = '{"rd_word",    1'b0, 2'd2, 32'h1FC0_0010, 32'h0, 32'hDEAD_BEEF, 3'd2, 4'b1111};
        vecs[1] = '{"wr_byte3",   1'b1, 2'd0, 32'h0000_0003, 32'h0000_00AB, 32'h0, 3'd0, 4'b1000};
        vecs[2] = '{"wr_byte1",   1'b1, 2'd0, 32'h0000_0101, 32'h0000_CD00, 32'h0, 3'd0, 4'b0010};
        vecs[3] = '{"wr_half_lo", 1'b1, 2'd1, 32'h0000_0200, 32'h0000_1234, 32'h0, 3'd1, 4'b0011};
        vecs[4] = '{"wr_half_hi", 1'b1, 2'd1, 32'h0000_0302, 32'h5678_0000, 32'h0, 3'd1, 4'b1100};
        vecs[5] = '{"wr_size3",   1'b1, 2'd3, 32'h0000_0410, 32'hCAFE_F00D, 32'h0, 3'd3, 4'b1111};
        vecs[6] = '{"rd_half",    1'b0, 2'd1, 32'h0000_0022, 32'h0, 32'h1234_5678, 3'd1, 4'b1111};

        rst = 1'b1;
        data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0;
        data_addr = 32'd0; data_wdata = 32'd0;
        arready = 1'b0; rid = 4'd0; rdata = 32'd0; rresp = 2'd0; rlast = 1'b1; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bid = 4'd0; bresp = 2'd0; bvalid = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        settle();

        // Reset state
        chk("reset valids", {27'd0, arvalid, rready, awvalid, wvalid, bready}, 32'd0);
        chk("reset addr_ok", 32'(data_addr_ok), 32'd0);
        chk("reset data_ok", 32'(data_data_ok), 32'd0);
        chk("reset araddr", araddr, 32'd0);
        chk("reset wdata", wdata, 32'd0);

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Half write, wready three cycles after awready
        step();
        drive_req(1'b1, 2'd1, 32'h0000_0102, 32'hBEEF_0000);
        settle();
        chk("dlyw addr_ok", 32'(data_addr_ok), 32'd1);
        step();
        data_req = 1'b0;
        awready = 1'b1;
        settle();
        chk("dlyw c1 aw/w/b", {29'd0, awvalid, wvalid, bready}, 32'b110);
        for (int c = 2; c <= 3; c++) begin
            step();
            awready = 1'b0;
            settle();
            chk($sformatf("dlyw c%0d aw/w/b", c), {29'd0, awvalid, wvalid, bready}, 32'b010);
        end
        step();
        wready = 1'b1;
        settle();
        chk("dlyw c4 aw/w/b", {29'd0, awvalid, wvalid, bready}, 32'b010);
        chk("dlyw wstrb", 32'(wstrb), 32'b1100);
        chk("dlyw data_ok c4", 32'(data_data_ok), 32'd0);
        step();
        wready = 1'b0;
        settle();
        chk("dlyw c5 aw/w/b", {29'd0, awvalid, wvalid, bready}, 32'b001);
        step();
        bvalid = 1'b1;
        settle();
        chk("dlyw data_ok", 32'(data_data_ok), 32'd1);
        step();
        bvalid = 1'b0;

        // Stalled read with a second request held throughout
        drive_req(1'b0, 2'd2, 32'h0000_0080, 32'd0);
        settle();
        chk("stall addr_ok c0", 32'(data_addr_ok), 32'd1);
        for (int c = 1; c <= 5; c++) begin
            step();
            drive_req(1'b0, 2'd2, 32'h0000_0084, 32'd0);
            settle();
            chk($sformatf("stall c%0d arvalid", c), 32'(arvalid), 32'd1);
            chk($sformatf("stall c%0d addr_ok", c), 32'(data_addr_ok), 32'd0);
            chk($sformatf("stall c%0d araddr", c), araddr, 32'h0000_0080);
        end
        step();
        arready = 1'b1;
        settle();
        chk("stall c6 arvalid", 32'(arvalid), 32'd1);
        for (int c = 7; c <= 9; c++) begin
            step();
            arready = 1'b0;
            settle();
            chk($sformatf("stall c%0d rr/av/ok", c), {29'd0, rready, arvalid, data_data_ok}, 32'b100);
            chk($sformatf("stall c%0d addr_ok", c), 32'(data_addr_ok), 32'd0);
        end
        step();
        rvalid = 1'b1;
        rdata = 32'hA5A5_0F0F;
        settle();
        chk("stall c10 data_ok", 32'(data_data_ok), 32'd1);
        chk("stall c10 addr_ok", 32'(data_addr_ok), 32'd0);
        chk("stall c10 rdata", data_rdata, 32'hA5A5_0F0F);
        step();
        rvalid = 1'b0;
        settle();
        chk("stall c11 addr_ok", 32'(data_addr_ok), 32'd1);
        chk("stall c11 data_ok", 32'(data_data_ok), 32'd0);
        step();
        data_req = 1'b0;
        arready = 1'b1;
        settle();
        chk("second araddr", araddr, 32'h0000_0084);
        step();
        arready = 1'b0;
        rvalid = 1'b1;
        rdata = 32'h0BAD_F00D;
        settle();
        chk("second data_ok", 32'(data_data_ok), 32'd1);
        step();
        rvalid = 1'b0;

        // Reset while waiting for read data
        drive_req(1'b0, 2'd2, 32'h0000_0040, 32'd0);
        step();
        data_req = 1'b0;
        arready = 1'b1;
        step();
        arready = 1'b0;
        settle();
        chk("rst pre rready", 32'(rready), 32'd1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        settle();
        chk("rst rready/arvalid", {30'd0, rready, arvalid}, 32'd0);
        chk("rst addr_ok", 32'(data_addr_ok), 32'd0);
        chk("rst araddr", araddr, 32'd0);
        run_vec('{"post_rst_rd", 1'b0, 2'd2, 32'h0000_0048, 32'h0, 32'h1357_9BDF, 3'd2, 4'b1111});

        // SLVERR write response still completes exactly once
        step();
        drive_req(1'b1, 2'd2, 32'h0000_0500, 32'h1111_2222);
        step();
        data_req = 1'b0;
        awready = 1'b1;
        wready = 1'b1;
        step();
        awready = 1'b0;
        wready = 1'b0;
        bvalid = 1'b1;
        bresp = 2'b10;
        pulses = 0;
        settle();
        if (data_data_ok) pulses++;
        for (int c = 0; c < 4; c++) begin
            step();
            bvalid = 1'b0;
            bresp = 2'b00;
            settle();
            if (data_data_ok) pulses++;
        end
        chk("slverr data_ok pulses", 32'(pulses), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
